// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit slices MSB first and stops on the first
// difference. Signed mode works by flipping operand MSBs at capture (offset binary).
module seq_mag_comp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH < 2) || (DIGIT == 0) || (WIDTH % DIGIT != 0)) begin : gen_bad_params
    $error("seq_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic [WIDTH-1:0]  a_sh, b_sh, msb_flip;
  logic [DIGIT-1:0]  a_sl, b_sl;
  logic              last_slice;

  // Shift the current slice up to the top so the slice select is constant.
  always_comb begin
    a_sh       = a_q << (idx_q * DIGIT);
    b_sh       = b_q << (idx_q * DIGIT);
    a_sl       = a_sh[WIDTH-1 -: DIGIT];
    b_sl       = b_sh[WIDTH-1 -: DIGIT];
    last_slice = (idx_q == IDXW'(NSLICE - 1));
    msb_flip   = {signed_mode, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A ^ msb_flip;
          b_d     = B ^ msb_flip;
          idx_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StCompare;
        end else begin
          state_d = StIdle;
        end
      end
      StCompare: begin
        if (a_sl > b_sl) begin
          gt_d    = 1'b1;
          state_d = StDone;
        end else if (a_sl < b_sl) begin
          lt_d    = 1'b1;
          state_d = StDone;
        end else if (last_slice) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy   = (state_q == StCompare);
  assign done   = (state_q == StDone);
  assign A_gt_B = gt_q;
  assign A_lt_B = lt_q;
  assign A_eq_B = eq_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: directed 8-bit vectors and handshake corner cases, plus an
// exhaustive 4-bit sweep over DIGIT = 1, 2, 4 against an integer comparison model.
module tb_seq_mag_comp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sm;
  logic [7:0] a, b;
  logic       busy, done, gt, lt, eq;

  seq_mag_comp #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .signed_mode(sm),
    .busy(busy), .done(done), .A_gt_B(gt), .A_lt_B(lt), .A_eq_B(eq)
  );

  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic [2:0] busy4, done4, gt4, lt4, eq4;

  seq_mag_comp #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .signed_mode(sm4),
    .busy(busy4[0]), .done(done4[0]), .A_gt_B(gt4[0]), .A_lt_B(lt4[0]), .A_eq_B(eq4[0])
  );
  seq_mag_comp #(.WIDTH(4), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .signed_mode(sm4),
    .busy(busy4[1]), .done(done4[1]), .A_gt_B(gt4[1]), .A_lt_B(lt4[1]), .A_eq_B(eq4[1])
  );
  seq_mag_comp #(.WIDTH(4), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .signed_mode(sm4),
    .busy(busy4[2]), .done(done4[2]), .A_gt_B(gt4[2]), .A_lt_B(lt4[2]), .A_eq_B(eq4[2])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // flags packed as {gt, lt, eq}
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] flags;
    int         lat;
  } vec_t;

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vsm,
                        output logic [2:0] fl, output int lat);
    a = va; b = vb; sm = vsm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy_done", {busy, done}, 2'b10);
    check("accept_flags_cleared", {gt, lt, eq}, 3'b000);
    lat = 0;
    fl  = 3'bxxx;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        fl  = {gt, lt, eq};
        check("done_busy_low", busy, 1'b0);
        break;
      end
    end
  endtask

  vec_t       vecs [11];
  logic [2:0] fl;
  int         lat;

  initial begin
    vecs[0]  = '{8'h80, 8'h7F, 1'b0, 3'b100, 1};
    vecs[1]  = '{8'h80, 8'h7F, 1'b1, 3'b010, 1};
    vecs[2]  = '{8'h5A, 8'h5A, 1'b0, 3'b001, 4};
    vecs[3]  = '{8'h12, 8'h13, 1'b0, 3'b010, 4};
    vecs[4]  = '{8'h34, 8'h24, 1'b0, 3'b100, 2};
    vecs[5]  = '{8'hFF, 8'h01, 1'b1, 3'b010, 1};
    vecs[6]  = '{8'hFE, 8'hFF, 1'b1, 3'b010, 4};
    vecs[7]  = '{8'h5A, 8'h5A, 1'b1, 3'b001, 4};
    vecs[8]  = '{8'hFF, 8'h00, 1'b0, 3'b100, 1};
    vecs[9]  = '{8'h70, 8'h60, 1'b1, 3'b100, 2};
    vecs[10] = '{8'h08, 8'h04, 1'b0, 3'b100, 3};

    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, gt, lt, eq}, 5'b0);
    check("reset_outputs_w4", {busy4, done4, gt4, lt4, eq4}, 15'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_stays_idle", {busy, done}, 2'b00);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, fl, lat);
      check($sformatf("vec%0d_flags", i), fl, vecs[i].flags);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle_hold", i), {done, busy, gt, lt, eq}, {2'b00, vecs[i].flags});
    end

    // start and operand changes while busy must be ignored
    a = 8'h13; b = 8'h12; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h00; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h01; b = 8'hFE; sm = 1'b1;
    lat = 0; fl = 3'bxxx;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; fl = {gt, lt, eq}; break; end
    end
    check("busy_abuse_flags", fl, 3'b100);
    check("busy_abuse_latency", lat, 4);

    // back-to-back: second start issued in the done cycle
    run_op(8'h80, 8'h7F, 1'b0, fl, lat);
    check("b2b_first_flags", fl, 3'b100);
    run_op(8'h5A, 8'h5A, 1'b0, fl, lat);
    check("b2b_second_flags", fl, 3'b001);
    check("b2b_second_latency", lat, 4);
    @(posedge clk); #1;

    // reset during the second COMPARE cycle
    a = 8'h5A; b = 8'h5A; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_outputs", {busy, done, gt, lt, eq}, 5'b0);
    rst = 1'b0;
    fl = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      fl = fl | {done, busy, 1'b0};
    end
    check("mid_reset_no_done", fl, 3'b000);
    run_op(8'h03, 8'h03, 1'b0, fl, lat);
    check("post_reset_flags", fl, 3'b001);
    check("post_reset_latency", lat, 4);
    @(posedge clk); #1;

    // reset wins over start
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    check("reset_beats_start", {busy, done, gt, lt, eq}, 5'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // exhaustive 4-bit sweep
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          int         l4 [3];
          logic [2:0] f4 [3];
          int         va, vb, el, p, dig;
          logic [2:0] ef;
          logic [3:0] x;
          a4 = 4'(ai); b4 = 4'(bi); sm4 = s[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          for (int k = 0; k < 3; k++) begin l4[k] = 0; f4[k] = 3'bxxx; end
          for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
              if (done4[k] && l4[k] == 0) begin
                l4[k] = c;
                f4[k] = {gt4[k], lt4[k], eq4[k]};
              end
            end
          end
          va = (s == 1 && ai >= 8) ? ai - 16 : ai;
          vb = (s == 1 && bi >= 8) ? bi - 16 : bi;
          ef = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
          x  = 4'(ai ^ bi);
          p  = 4;
          for (int bit_i = 3; bit_i >= 0; bit_i--) begin
            if (x[bit_i]) begin p = 3 - bit_i; break; end
          end
          for (int k = 0; k < 3; k++) begin
            dig = (k == 0) ? 1 : (k == 1) ? 2 : 4;
            el  = (p == 4) ? 4 / dig : p / dig + 1;
            check($sformatf("exh_d%0d_sm%0d_a%0h_b%0h", dig, s, ai, bi),
                  {f4[k], 4'(l4[k])}, {ef, 4'(el)});
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mag_comp.md
# seq_mag_comp

Parametrised, multi-cycle magnitude comparator: the next generation of the 4-bit combinational `mag_comp`. It compares two WIDTH-bit operands, DIGIT bits per clock, MSB slice first, and terminates early on the first differing slice. It supports an unsigned or two's-complement mode selected per operation. It sits on a start/busy/done handshake so wide comparisons do not lengthen the datapath critical path.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; ≥2.
- `DIGIT`, default 2: bits compared per cycle; must divide `WIDTH`. NSLICE = WIDTH/DIGIT.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a comparison; accepted only when `busy`=0.
- `A`  in  WIDTH  operand A; sampled only on the accepting edge.
- `B`  in  WIDTH  operand B; sampled only on the accepting edge.
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned; sampled only on the accepting edge.
- `busy`  out  1  comparison in progress.
- `done`  out  1  one-cycle pulse; result flags valid.
- `A_gt_B`  out  1  registered result: A > B.
- `A_lt_B`  out  1  registered result: A < B.
- `A_eq_B`  out  1  registered result: A == B.

## Operation
- FSM states: IDLE, COMPARE, DONE.
- IDLE, `start`=1: latch A, B and mode; clear all three flags to 0; slice index ← 0 (MSB slice); go to COMPARE. With `start`=0, stay in IDLE.
- Signed mode: invert the MSB of both latched operands at capture (offset-binary). Unsigned slice compare then gives the signed result.
- COMPARE: each cycle, compare slice `i` (bits WIDTH-1-i·DIGIT down to WIDTH-(i+1)·DIGIT) of A against the same slice of B.
  - A slice > B slice: set `A_gt_B`, go to DONE.
  - A slice < B slice: set `A_lt_B`, go to DONE.
  - Slices equal and i = NSLICE-1: set `A_eq_B`, go to DONE.
  - Otherwise: i ← i+1.
- DONE: `done`=1 for exactly this cycle; `busy`=0. `start`=1 here is accepted (back-to-back), same actions as IDLE + start. Otherwise go to IDLE.
- Flags are one-hot whenever `done`=1. They hold their value through IDLE until the next accepted `start` clears them.
- `start` while `busy`=1 is ignored; input changes during COMPARE have no effect.
- Slice counter width: clog2(NSLICE), minimum 1 bit. The counter never wraps; it exits at NSLICE-1.

## Timing
- Reset (any state, including mid-COMPARE): state → IDLE, `busy`=0, `done`=0, `A_gt_B`=`A_lt_B`=`A_eq_B`=0, counter=0. The operation in flight is discarded, with no `done`.
- `start` accepted at edge k: `busy`=1 after edge k.
- First differing slice index d: the result is registered at edge k+1+d. `done`=1 and `busy`=0 during the cycle after that edge.
- Latency from the accepting edge to `done` is d+1 cycles. Equal operands take NSLICE cycles. The worst case is NSLICE.
- Throughput: with `start` held high in every DONE cycle, one comparison is accepted per (latency+1) cycles.
- `rst` and `start` in the same cycle: reset wins.
- All outputs are registered; none is combinational from inputs.

## Test plan
- Unsigned, WIDTH=8, DIGIT=2: A=0x80, B=0x7F, start at edge k → `done` after edge k+1, `A_gt_B`=1, the other flags 0, `busy` high for 1 cycle.
- Signed, same operands (−128 vs 127) → `done` after edge k+1 with `A_lt_B`=1.
- Equal and late difference: A=B=0x5A → `A_eq_B`=1 after 4 cycles. A=0x12, B=0x13 → `A_lt_B`=1 after 4 cycles.
- Handshake abuse:
  - Pulse `start` with A=0x00, B=0xFF while busy → ignored; the original result is reported.
  - Assert `start` during the `done` cycle → second operation accepted with no idle cycle.
  - Change A/B mid-COMPARE → result unaffected.
- Reset mid-operation: assert `rst` in the 2nd COMPARE cycle → next cycle all outputs 0, no `done`. A following start (A=3, B=3) completes normally with `A_eq_B`=1.
- Exhaustive check: WIDTH=4 with DIGIT=1, 2 and 4, both modes, all 256 (A,B) pairs, compared against a behavioural model. Checks on every `done`: flags one-hot, correct result, and latency = first-differing-slice index + 1 (NSLICE for equal operands).
